// File: rtl/tnn_feature_loader_pkg.sv
// Shared types and constants for the TNN feature loaders.
package tnn_pkg;

  localparam int N_FEAT = 4;
  localparam int Q_W    = 2;
  localparam int IDX_W  = 2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EVAL    = 2'd1,
    HOLD    = 2'd2
  } state_t;

  typedef logic [N_FEAT-1:0][Q_W-1:0] feat_vec_t;

endpackage

// File: rtl/tnn_feature_loader_quantizer.sv
// Combinational 2-bit quantizer: compares an unsigned sample against three
// ascending thresholds (TH1 <= TH2 <= TH3 < 2**FEAT_W).
module tnn_quantizer #(
  parameter int FEAT_W = 8,
  parameter int TH1    = 64,
  parameter int TH2    = 128,
  parameter int TH3    = 192
) (
  input  logic [FEAT_W-1:0] sample_i,
  output logic [1:0]        code_o
);

  int sample_int;

  always_comb begin
    sample_int = int'(sample_i);
    if (sample_int >= TH3)      code_o = 2'd3;
    else if (sample_int >= TH2) code_o = 2'd2;
    else if (sample_int >= TH1) code_o = 2'd1;
    else                        code_o = 2'd0;
  end

endmodule

// File: rtl/tnn_feature_loader.sv
// Stream front end for a 4-feature 2-bit classifier: collects a frame,
// presents it, captures the class bit. Optional counters: TNN_LOADER_STATS_EN.
module tnn_feature_loader
  import tnn_pkg::*;
#(
  parameter int FEAT_W = 8,
  parameter int TH1    = 64,
  parameter int TH2    = 128,
  parameter int TH3    = 192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_data,
  input  logic              s_last,
  output logic [1:0]        input_a,
  output logic [1:0]        input_b,
  output logic [1:0]        input_c,
  output logic [1:0]        input_d,
  input  logic              cgp_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_class,
`ifdef TNN_LOADER_STATS_EN
  output logic [15:0]       stat_frames,
  output logic [15:0]       stat_pos,
`endif
  output logic              m_frame_err
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  feat_vec_t        feat_q, feat_d;
  logic             m_valid_q, m_valid_d;
  logic             m_class_q, m_class_d;
  logic             err_q, err_d;
  logic [1:0]       code;

  tnn_quantizer #(
    .FEAT_W (FEAT_W),
    .TH1    (TH1),
    .TH2    (TH2),
    .TH3    (TH3)
  ) u_quant (
    .sample_i (s_data),
    .code_o   (code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      feat_q    <= '0;
      m_valid_q <= 1'b0;
      m_class_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      feat_q    <= feat_d;
      m_valid_q <= m_valid_d;
      m_class_q <= m_class_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    feat_d    = feat_q;
    m_valid_d = m_valid_q;
    m_class_d = m_class_q;
    err_d     = err_q;
    s_ready   = 1'b0;
    case (state_q)
      COLLECT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          feat_d[idx_q] = code;
          // A frame is well formed only when s_last coincides with beat 3.
          if (s_last) begin
            idx_d = '0;
            if (idx_q == IDX_W'(N_FEAT - 1)) state_d = EVAL;
            else                             err_d   = 1'b1;
          end else if (idx_q == IDX_W'(N_FEAT - 1)) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      EVAL: begin
        m_class_d = cgp_out;
        m_valid_d = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          idx_d     = '0;
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign input_a     = feat_q[0];
  assign input_b     = feat_q[1];
  assign input_c     = feat_q[2];
  assign input_d     = feat_q[3];
  assign m_valid     = m_valid_q;
  assign m_class     = m_class_q;
  assign m_frame_err = err_q;

`ifdef TNN_LOADER_STATS_EN
  logic [15:0] stat_frames_q, stat_pos_q;
  logic        handoff;

  assign handoff = m_valid_q && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames_q <= '0;
      stat_pos_q    <= '0;
    end else if (handoff) begin
      if (stat_frames_q != 16'hFFFF) stat_frames_q <= stat_frames_q + 16'd1;
      if (m_class_q && stat_pos_q != 16'hFFFF) stat_pos_q <= stat_pos_q + 16'd1;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_pos    = stat_pos_q;
`endif

endmodule
